rr_arbiter_32: RTL
==================

# rr_arbiter_32

Round-robin arbiter that selects one of 32 requesters and drives a registered one-hot grant vector. That vector feeds directly into the `state` input of the downstream 32:1 one-hot data mux (`mux_32`), and the arbiter holds it stable until the consumer accepts the transfer. A `lock` input extends a grant across multi-beat packets. The pointer advances only on packet completion, giving per-packet fairness across the 32 ports of the switch.

## Interface
- `PORT_NUM`, 32: number of requesters. Fixed at 32 to match the downstream mux; any other value is illegal.
- `IDX_WIDTH`, 5: width of index and pointer, equal to log2(PORT_NUM).

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous reset, active-high. Clears all state immediately; released synchronously by the environment.
- `req`  in  32  per-port request level. Bit i high means port i has data.
- `ready`  in  1  the consumer accepts the currently granted beat at this rising edge.
- `lock`  in  1  sampled on an accept edge. High means the current packet continues, so keep the same grant.
- `grant`  out  32  registered one-hot grant, or all-zero. Connects to the mux `state` input.
- `grant_vld`  out  1  registered; equals (`grant` != 0).
- `grant_idx`  out  5  registered binary index of the granted port. 0 when idle.
- `ptr`  out  5  registered round-robin pointer, i.e. the highest-priority port for the next new arbitration.

## Operation
- Two states.
  - IDLE: `grant` = 0.
  - BUSY: exactly one bit of `grant` is set.
- Search function `pick(req, start)`: returns the first index j, scanning start, start+1, …, 31, 0, …, start-1 (mod 32), with `req[j]` = 1. Returns none if `req` = 0. It is combinational and must handle wrap-around: a request below `start` is reached after scanning 31.
- IDLE:
  - If `req` != 0: next grant is the one-hot of `pick(req, ptr)` and the state moves to BUSY.
  - Otherwise stay in IDLE.
  - `ptr` is unchanged in IDLE.
- BUSY without `ready`: `grant`, `grant_idx` and `ptr` hold. Changes on `req`, including the granted bit falling, are ignored.
- BUSY with `ready` and `lock`=1: this is a mid-packet beat.
  - The grant is kept for the same port.
  - `ptr` is unchanged.
  - The port keeps the grant even if its `req` bit is 0 at that edge.
- BUSY with `ready` and `lock`=0: this is end of packet.
  - `ptr` ← (`grant_idx` + 1) mod 32. 5-bit wrap, so 31 + 1 → 0.
  - If `req` != 0, the new grant is the one-hot of `pick(req, grant_idx+1)` and the state stays BUSY. This is back-to-back with no bubble cycle. The same port may be re-granted only if it is the sole requester.
  - If `req` = 0, the state goes to IDLE and `grant`, `grant_vld` and `grant_idx` go to 0.
- `ready` and `lock` are don't-care in IDLE.
- `grant` is never multi-hot and never changes except at an accept edge or the IDLE→BUSY edge. The downstream mux default path (index 0) is never relied on while `grant_vld`=1.
- Reset values: state = IDLE, `grant` = 32'h0, `grant_vld` = 0, `grant_idx` = 0, `ptr` = 0.
- Reset asserted mid-BUSY: all outputs clear asynchronously, so the in-flight packet is abandoned. The first arbitration after release starts from port 0.

## Timing
- Latency from `req` to `grant` is 1 cycle. A request sampled at edge n with the arbiter in IDLE yields `grant` valid after edge n, i.e. in cycle n+1.
- The accept handshake completes at any edge where `grant_vld`=1 and `ready`=1. The next grant appears after that same edge.
- Sustained throughput is one beat per cycle while `ready` stays high.
- All outputs come straight from flops, so there is no combinational path from `req`, `ready` or `lock` to any output. The downstream mux therefore sees a glitch-free one-hot select.
- The critical path is the 32-bit circular priority search. Implement it as a masked and unmasked priority encoder, not a 32-step ripple loop.

## Test plan
- Reset, then `req`=32'h0000_0001 → after 1 edge `grant`=32'h1, `grant_idx`=0, `grant_vld`=1, `ptr`=0. Assert `ready` with `lock`=0 and `req`=0 → IDLE, `grant`=0, `ptr`=1.
- Fairness: `req`=32'hFFFF_FFFF, `ready`=1, `lock`=0 held for 33 cycles → `grant_idx` runs 0,1,…,31,0 with no bubble, `ptr` trails by one and wraps 31→0.
- Wrap search: `ptr`=30, `req`=32'h0000_0006 → grant port 1 (32'h2). Then accept with `lock`=0 and `req` still 6 → grant port 2, `ptr`=2.
- Stall and lock: grant on port 5, `ready`=0 for 4 cycles while `req[5]` drops and `req[7]` rises → `grant` stays 32'h20. Accept with `lock`=1 → port 5 kept and `ptr` unchanged. Accept with `lock`=0 → grant port 7 (32'h80), `ptr`=6.
- Sole requester: only `req[9]` set, 3 accepts with `lock`=0 → `grant` remains 32'h200 each cycle, `ptr`=10.
- Async reset mid-packet: BUSY on port 12 with `lock` held, assert `rst` between edges → `grant`, `grant_vld`, `grant_idx` and `ptr` are 0 immediately, before the next edge. After release, `req`=32'h1000 → grant port 12 after 1 edge.

Source files
------------

// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter over 32 requesters with a registered one-hot grant that
// holds until accepted; lock keeps the grant across multi-beat packets.
module rr_arbiter_32 #(
  parameter int PORT_NUM  = 32,
  parameter int IDX_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_NUM-1:0]   req_i,
  input  logic                  ready_i,
  input  logic                  lock_i,
  output logic [PORT_NUM-1:0]   grant_o,
  output logic                  grant_vld_o,
  output logic [IDX_WIDTH-1:0]  grant_idx_o,
  output logic [IDX_WIDTH-1:0]  ptr_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PORT_NUM-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;

  logic [IDX_WIDTH-1:0]  nextPtr;
  logic [IDX_WIDTH-1:0]  startIdx;
  logic [PORT_NUM-1:0]   maskedReq;
  logic [PORT_NUM-1:0]   candReq;
  logic [PORT_NUM-1:0]   pickOh;
  logic [IDX_WIDTH-1:0]  pickIdx;

  // Circular search: lowest request at or above startIdx, else lowest overall.
  always_comb begin
    nextPtr   = idx_q + IDX_WIDTH'(1);
    startIdx  = (state_q == IDLE) ? ptr_q : nextPtr;
    maskedReq = req_i & ({PORT_NUM{1'b1}} << startIdx);
    candReq   = (maskedReq != '0) ? maskedReq : req_i;
    pickOh    = candReq & (~candReq + PORT_NUM'(1));
    pickIdx   = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (pickOh[i]) begin
        pickIdx = pickIdx | IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req_i != '0) begin
          state_d = BUSY;
          grant_d = pickOh;
          idx_d   = pickIdx;
        end
      end
      BUSY: begin
        // Only an accept without lock ends the packet and moves the pointer.
        if (ready_i && !lock_i) begin
          ptr_d = nextPtr;
          if (req_i != '0) begin
            grant_d = pickOh;
            idx_d   = pickIdx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_vld_o = (state_q == BUSY);
  assign grant_idx_o = idx_q;
  assign ptr_o       = ptr_q;

endmodule
